// File: rtl/fix_tx_msg_buffer_pkg.sv
// Shared constants for the FIX transmit buffer: ASCII codes used by the trailer
// parser and the receive FSM state encoding.
package fix_tx_msg_buffer_pkg;

  localparam logic [7:0] ASCII_SOH = 8'h01;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_1   = 8'h31;
  localparam logic [7:0] ASCII_8   = 8'h38;
  localparam logic [7:0] ASCII_9   = 8'h39;
  localparam logic [7:0] ASCII_EQ  = 8'h3D;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FIELD,
    ST_FSTART,
    ST_T1,
    ST_T0,
    ST_D1,
    ST_D2,
    ST_D3,
    ST_CSOH
  } rx_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/fix_tx_byte_ram.sv
// Simple dual-port byte store: one write port, one registered read port.
// Each entry holds {last, byte}.
module fix_tx_byte_ram #(
  parameter int AW = 10,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fix_tx_msg_buffer.sv
// Store-and-forward FIX transmit buffer: parses the "10=ddd<SOH>" trailer, checks the
// checksum, and releases only complete valid messages to the TOE via valid/ready.
module fix_tx_msg_buffer
  import fix_tx_msg_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [7:0]            data_i,
  input  logic                  tx_ready_i,
  output logic                  tx_valid_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_last_o,
  output logic [DEPTH_LOG2:0]   msg_count_o,
  output logic                  bad_checksum_o,
  output logic                  overflow_o,
  output logic                  empty_o
);

  rx_state_t              state;
  logic [DEPTH_LOG2-1:0]  wr_ptr, commit_ptr, rd_ptr;
  logic [DEPTH_LOG2-1:0]  wr_ptr_inc, wr_ptr_next, rd_ptr_next;
  logic [7:0]             sum, snap;
  logic [9:0]             ck, ck_digit;
  logic                   ovf, ovf_now, store, full, ram_we, commit, drop, last_byte;
  logic                   rd_fire, tx_valid_reg, bad_pulse, ovf_pulse;
  logic [8:0]             ram_q;
  logic [DEPTH_LOG2:0]    msg_count;

  assign wr_ptr_inc  = wr_ptr + DEPTH_LOG2'(1);
  assign rd_fire     = tx_valid_reg & tx_ready_i;
  assign rd_ptr_next = rd_fire ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;

  always_comb begin
    store     = 1'b0;
    last_byte = 1'b0;
    commit    = 1'b0;
    drop      = 1'b0;
    ck_digit  = ck * 10'd10 + {2'b00, data_i - ASCII_0};
    case (state)
      ST_IDLE: store = valid_i && (data_i == ASCII_8);
      ST_D1, ST_D2, ST_D3: begin
        store = valid_i && is_digit(data_i);
        drop  = valid_i && !is_digit(data_i);
      end
      ST_CSOH: begin
        last_byte = 1'b1;
        store     = valid_i && (data_i == ASCII_SOH);
        drop      = valid_i && (data_i != ASCII_SOH);
      end
      default: store = valid_i;
    endcase
    // Once storage filled up, the rest of the message is parsed but never written.
    full    = (wr_ptr_inc == rd_ptr);
    ovf_now = ovf | (store & full);
    ram_we  = store & ~ovf_now;
    if (state == ST_CSOH && store) begin
      if (!ovf_now && ck < 10'd256 && ck[7:0] == snap) commit = 1'b1;
      else                                              drop   = 1'b1;
    end
    wr_ptr_next = drop ? commit_ptr : (ram_we ? wr_ptr_inc : wr_ptr);
  end

  fix_tx_byte_ram #(.AW(DEPTH_LOG2), .DW(9)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata ({last_byte, data_i}),
    .raddr (rd_ptr_next),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      rd_ptr       <= '0;
      sum          <= '0;
      snap         <= '0;
      ck           <= '0;
      ovf          <= 1'b0;
      tx_valid_reg <= 1'b0;
      bad_pulse    <= 1'b0;
      ovf_pulse    <= 1'b0;
      msg_count    <= '0;
    end else begin
      bad_pulse    <= drop & ~ovf_now;
      ovf_pulse    <= drop & ovf_now;
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      if (commit) commit_ptr <= wr_ptr_next;
      // Uses the pre-commit pointer, which gives the two-cycle commit-to-valid latency.
      tx_valid_reg <= (rd_ptr_next != commit_ptr);
      if (commit && !(rd_fire && ram_q[8]))      msg_count <= msg_count + (DEPTH_LOG2+1)'(1);
      else if (!commit && rd_fire && ram_q[8])   msg_count <= msg_count - (DEPTH_LOG2+1)'(1);

      if (valid_i) begin
        if (commit || drop) begin
          state <= ST_IDLE;
          sum   <= '0;
          ck    <= '0;
          ovf   <= 1'b0;
        end else begin
          ovf <= ovf_now;
          case (state)
            ST_IDLE: begin
              if (data_i == ASCII_8) begin
                sum   <= data_i;
                state <= ST_FIELD;
              end
            end
            ST_FIELD: begin
              sum <= sum + data_i;
              if (data_i == ASCII_SOH) begin
                snap  <= sum + data_i;
                state <= ST_FSTART;
              end
            end
            ST_FSTART, ST_T1, ST_T0: begin
              sum <= sum + data_i;
              if (state == ST_FSTART && data_i == ASCII_1)      state <= ST_T1;
              else if (state == ST_T1 && data_i == ASCII_0)     state <= ST_T0;
              else if (state == ST_T0 && data_i == ASCII_EQ) begin
                ck    <= '0;
                state <= ST_D1;
              end else if (data_i == ASCII_SOH) begin
                snap  <= sum + data_i;
                state <= ST_FSTART;
              end else state <= ST_FIELD;
            end
            ST_D1: begin ck <= ck_digit; state <= ST_D2;   end
            ST_D2: begin ck <= ck_digit; state <= ST_D3;   end
            ST_D3: begin ck <= ck_digit; state <= ST_CSOH; end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign tx_valid_o     = tx_valid_reg;
  assign tx_data_o      = tx_valid_reg ? ram_q[7:0] : 8'h00;
  assign tx_last_o      = tx_valid_reg & ram_q[8];
  assign msg_count_o    = msg_count;
  assign bad_checksum_o = bad_pulse;
  assign overflow_o     = ovf_pulse;
  assign empty_o        = ~tx_valid_reg;

endmodule

// File: tb/tb_fix_tx_msg_buffer.sv
// Directed bench for fix_tx_msg_buffer: a large and a 16-entry instance, with a byte
// scoreboard filled when valid messages are driven and drained by a TOE-side monitor.
module tb_fix_tx_msg_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_a, valid_b, ready, sel;
  logic [7:0]  data;
  logic        a_valid, a_last, a_bad, a_ovf, a_empty;
  logic [7:0]  a_data;
  logic [10:0] a_count;
  logic        b_valid, b_last, b_bad, b_ovf, b_empty;
  logic [7:0]  b_data;
  logic [4:0]  b_count;

  fix_tx_msg_buffer #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_a), .data_i(data), .tx_ready_i(ready),
    .tx_valid_o(a_valid), .tx_data_o(a_data), .tx_last_o(a_last), .msg_count_o(a_count),
    .bad_checksum_o(a_bad), .overflow_o(a_ovf), .empty_o(a_empty));

  fix_tx_msg_buffer #(.DEPTH_LOG2(4)) dut_small (
    .clk(clk), .rst(rst), .valid_i(valid_b), .data_i(data), .tx_ready_i(ready),
    .tx_valid_o(b_valid), .tx_data_o(b_data), .tx_last_o(b_last), .msg_count_o(b_count),
    .bad_checksum_o(b_bad), .overflow_o(b_ovf), .empty_o(b_empty));

  wire        m_valid = sel ? b_valid : a_valid;
  wire [7:0]  m_data  = sel ? b_data  : a_data;
  wire        m_last  = sel ? b_last  : a_last;
  wire        m_bad   = sel ? b_bad   : a_bad;
  wire        m_ovf   = sel ? b_ovf   : a_ovf;
  wire        m_empty = sel ? b_empty : a_empty;
  wire [10:0] m_count = sel ? {6'b0, b_count} : a_count;

  int tests = 0, fails = 0;
  int bad_cnt = 0, ovf_cnt = 0, last_cnt = 0;
  logic [8:0] exp_q[$];

  always @(negedge clk) begin
    if (rst) begin
      if (m_bad) bad_cnt++;
      if (m_ovf) ovf_cnt++;
      if (m_valid && ready) begin
        if (m_last) last_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $error("FAIL tx_byte observed=%h required=no_output", {m_last, m_data});
        end else begin
          logic [8:0] exp;
          exp = exp_q.pop_front();
          assert ({m_last, m_data} === exp) else begin
            fails++;
            $error("FAIL tx_byte observed=%h required=%h", {m_last, m_data}, exp);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  function automatic string with_ck(input string body);
    int s = 0;
    for (int i = 0; i < body.len(); i++) s += (body[i] == 8'h7C) ? 1 : int'(body[i]);
    return {body, $sformatf("10=%03d|", s % 256)};
  endfunction

  // '|' in the text stands for SOH; ok=1 queues the bytes as expected TOE output.
  task automatic send(input string s, input bit ok);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] b;
      b = s[i];
      if (b == 8'h7C) b = 8'h01;
      @(posedge clk); #1;
      valid_a = ~sel;
      valid_b = sel;
      data    = b;
      if (ok) exp_q.push_back({(i == s.len() - 1), b});
    end
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    $display("[TB] sent %0d bytes on %s dut, expect_commit=%0d: %s", s.len(), sel ? "small" : "large", ok, s);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!(m_count == 0 && m_empty && exp_q.size() == 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_drain_in_time"}, int'(n < 400), 1);
  endtask

  string msg1, bad1, ovf_msg, small_msg;
  int l0, b0, o0;

  initial begin
    rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0; data = 8'h00; ready = 1'b1; sel = 1'b0;
    msg1      = with_ck("8=FIX.4.2|9=5|35=0|");
    bad1      = "8=FIX.4.2|9=5|35=0|10=000|";
    ovf_msg   = with_ck("8=FIX.4|9=00|");
    small_msg = with_ck("8=AB|");
    #2;
    check("rst_tx_valid", a_valid, 0);
    check("rst_tx_data", a_data, 0);
    check("rst_count", a_count, 0);
    check("rst_empty", a_empty, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // single valid message, first byte two cycles after closing SOH
    l0 = last_cnt;
    send(msg1, 1);
    check("t1_count_after_commit", m_count, 1);
    check("t1_valid_before_latency", m_valid, 0);
    @(posedge clk); #1;
    check("t1_valid_at_latency", m_valid, 1);
    wait_drain("t1");
    check("t1_last_seen", last_cnt - l0, 1);

    // wrong checksum
    b0 = bad_cnt;
    send(bad1, 0);
    repeat (3) @(posedge clk); #1;
    check("t2_bad_pulse", bad_cnt - b0, 1);
    check("t2_tx_valid", m_valid, 0);
    check("t2_empty", m_empty, 1);

    // two messages held back, then released
    ready = 1'b0;
    send(msg1, 1);
    send(msg1, 1);
    repeat (3) @(posedge clk); #1;
    check("t3_count_two", m_count, 2);
    check("t3_valid_held", m_valid, 1);
    l0 = last_cnt;
    ready = 1'b1;
    wait_drain("t3");
    check("t3_last_twice", last_cnt - l0, 2);

    // garbage before '8', then a malformed digit
    l0 = last_cnt;
    send("XYZ|\n", 0);
    send(msg1, 1);
    wait_drain("t4");
    check("t4_last_seen", last_cnt - l0, 1);
    b0 = bad_cnt;
    send("8=FIX.4.2|9=5|35=0|10=25x", 0);
    repeat (2) @(posedge clk); #1;
    check("t4_bad_digit_pulse", bad_cnt - b0, 1);
    check("t4_no_output", m_valid, 0);

    // 16-entry instance: 20-byte message overflows, 12-byte one commits
    sel = 1'b1;
    o0 = ovf_cnt; b0 = bad_cnt; l0 = last_cnt;
    check("t5_ovf_msg_len", ovf_msg.len(), 20);
    send(ovf_msg, 0);
    repeat (3) @(posedge clk); #1;
    check("t5_ovf_pulse", ovf_cnt - o0, 1);
    check("t5_no_bad_pulse", bad_cnt - b0, 0);
    check("t5_no_output", m_valid, 0);
    send(small_msg, 1);
    wait_drain("t5");
    check("t5_small_last", last_cnt - l0, 1);
    sel = 1'b0;

    // asynchronous reset with a committed message and a partial one pending
    ready = 1'b0;
    send(msg1, 1);
    send(msg1.substr(0, 6), 0);
    check("t6_count_before_rst", m_count, 1);
    check("t6_valid_before_rst", m_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_data", m_data, 0);
    check("t6_rst_count", m_count, 0);
    check("t6_rst_empty", m_empty, 1);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    ready = 1'b1;
    l0 = last_cnt;
    send(msg1, 1);
    wait_drain("t6");
    check("t6_last_after_rst", last_cnt - l0, 1);

    repeat (3) @(posedge clk); #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
